multi_lsd_line_buffer: RTL

//  N-channel, double-buffered store for line segments emitted by simple_lsd, one channel per camera.
//  Per channel: collects one frame of segments in a write bank and swaps banks at end of frame.
//  The completed frame is then exposed to the PS (pspl_comm) through a single shared read port.

---
 rtl/multi_lsd_line_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multi_lsd_line_buffer.sv
// N-channel, double-buffered line-segment store with a single shared registered read port.
// Optional build macro MLB_RD_LOCK_EN adds per-channel rd_lock to freeze the published frame.
module multi_lsd_line_buffer #(
  parameter int NUM_CH  = 2,
  parameter int H_BITW  = 10,
  parameter int V_BITW  = 9,
  parameter int DEPTH   = 256,
  localparam int CH_BITW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int E_BITW  = 2 * (V_BITW + H_BITW),
  localparam int C_BITW  = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef MLB_RD_LOCK_EN
  input  logic [NUM_CH-1:0]          rd_lock,
`endif
  input  logic [NUM_CH-1:0]          in_flag,
  input  logic [NUM_CH-1:0]          in_valid,
  input  logic [NUM_CH*V_BITW-1:0]   in_start_v,
  input  logic [NUM_CH*V_BITW-1:0]   in_end_v,
  input  logic [NUM_CH*H_BITW-1:0]   in_start_h,
  input  logic [NUM_CH*H_BITW-1:0]   in_end_h,
  input  logic                       rd_req,
  input  logic [CH_BITW-1:0]         rd_ch,
  input  logic [31:0]                rd_addr,
  output logic                       rd_valid,
  output logic [V_BITW-1:0]          rd_start_v,
  output logic [V_BITW-1:0]          rd_end_v,
  output logic [H_BITW-1:0]          rd_start_h,
  output logic [H_BITW-1:0]          rd_end_h,
  output logic [NUM_CH-1:0]          out_ready,
  output logic [NUM_CH*32-1:0]       out_line_num,
  output logic [NUM_CH-1:0]          out_overflow
);

  localparam int A_BITW = $clog2(DEPTH);

  typedef logic [E_BITW-1:0] entry_t;
  typedef logic [C_BITW-1:0] cnt_t;

  // Two banks per channel; bank sel_q[c] is written, the other one is published.
  entry_t seg_mem [NUM_CH][2][DEPTH];

  logic [NUM_CH-1:0] sel_q, sel_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [NUM_CH-1:0] ovf_pend_q, ovf_pend_d;
  logic [NUM_CH-1:0] ovf_out_q, ovf_out_d;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] lock_w;
  cnt_t              wr_cnt_q   [NUM_CH];
  cnt_t              wr_cnt_d   [NUM_CH];
  cnt_t              line_num_q [NUM_CH];
  cnt_t              line_num_d [NUM_CH];
  entry_t            wr_entry   [NUM_CH];

  logic                rd_valid_q, rd_valid_d;
  entry_t              rd_data_q, rd_data_d;
  logic                rd_ch_ok;
  logic                rd_hit;
  logic [CH_BITW-1:0]  rd_idx;
  entry_t              rd_word;

`ifdef MLB_RD_LOCK_EN
  assign lock_w = rd_lock;
`else
  assign lock_w = '0;
`endif

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wr_entry[c] = {in_start_v[c*V_BITW +: V_BITW], in_end_v[c*V_BITW +: V_BITW],
                     in_start_h[c*H_BITW +: H_BITW], in_end_h[c*H_BITW +: H_BITW]};
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    sel_d      = sel_q;
    ready_d    = ready_q;
    ovf_pend_d = ovf_pend_q;
    ovf_out_d  = ovf_out_q;
    wr_en      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_cnt_d[c]   = wr_cnt_q[c];
      line_num_d[c] = line_num_q[c];
      wr_en[c]      = in_valid[c] && (wr_cnt_q[c] != cnt_t'(DEPTH));
      if (wr_en[c]) begin
        wr_cnt_d[c] = wr_cnt_q[c] + cnt_t'(1);
      end
      if (in_valid[c] && !wr_en[c]) begin
        ovf_pend_d[c] = 1'b1;
      end
      // A segment arriving with the flag belongs to the frame that is ending.
      if (in_flag[c]) begin
        if (!lock_w[c]) begin
          sel_d[c]      = ~sel_q[c];
          ready_d[c]    = 1'b1;
          line_num_d[c] = wr_cnt_d[c];
          ovf_out_d[c]  = ovf_pend_d[c];
        end
        wr_cnt_d[c]   = '0;
        ovf_pend_d[c] = 1'b0;
      end
    end
  end

  // Reads sample the pre-edge bank select and count, so a coincident swap still serves the old frame.
  always_comb begin
    rd_ch_ok   = (32'(rd_ch) < 32'(NUM_CH));
    rd_idx     = rd_ch_ok ? rd_ch : '0;
    rd_hit     = rd_ch_ok && ready_q[rd_idx] && (rd_addr < 32'(line_num_q[rd_idx]));
    rd_word    = seg_mem[rd_idx][~sel_q[rd_idx]][rd_addr[A_BITW-1:0]];
    rd_valid_d = rd_req;
    rd_data_d  = (rd_req && rd_hit) ? rd_word : '0;
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '0;
      ready_q    <= '0;
      ovf_pend_q <= '0;
      ovf_out_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_cnt_q[c]   <= '0;
        line_num_q[c] <= '0;
      end
    end else begin
      sel_q      <= sel_d;
      ready_q    <= ready_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_out_q  <= ovf_out_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_cnt_q[c]   <= wr_cnt_d[c];
        line_num_q[c] <= line_num_d[c];
      end
    end
  end

  // NOTE: the segment memory has no reset; entries beyond the published count are never exposed.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) begin
        seg_mem[c][sel_q[c]][wr_cnt_q[c][A_BITW-1:0]] <= wr_entry[c];
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign {rd_start_v, rd_end_v, rd_start_h, rd_end_h} = rd_data_q;
  assign out_ready    = ready_q;
  assign out_overflow = ovf_out_q;

  always_comb begin
    out_line_num = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      out_line_num[c*32 +: 32] = 32'(line_num_q[c]);
    end
  end

endmodule
